// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 console UART receiver, oversampled by rx_baud_clk ticks.
//             Synchronizes rxd, validates the start bit at mid-bit, samples
//             data LSB-first, checks the stop bit and holds the byte for the
//             bus side behind a ready/read handshake.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_baud_clk,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_frame_err
);

  localparam int c_cnt_w = $clog2(OVERSAMPLE);
  localparam int c_idx_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_mid  = c_cnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_WAITHI = 3'd4
  } state_t;

  logic                 rxd_meta_q;
  logic                 rxd_s_q;
  logic                 baud_q;
  logic                 baud_prev_q;
  logic                 w_tick;

  state_t               state_q,   state_d;
  logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
  logic [c_idx_w-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 ready_q,   ready_d;
  logic                 overrun_q, overrun_d;
  logic                 ferr_q,    ferr_d;

  // Rising edge of the registered baud clock marks one oversample tick.
  assign w_tick = baud_q & ~baud_prev_q;

  // Input synchronizer, baud edge detector and all receiver state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      baud_q      <= 1'b0;
      baud_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      baud_q      <= rx_baud_clk;
      baud_prev_q <= baud_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  // Frame FSM: advances only on ticks; a read clears the flags unless a byte
  // completes in the same cycle, in which case the completion wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;

    if (rd) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (w_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s_q) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          cnt_d = cnt_q + c_cnt_one;
          if (cnt_q == c_cnt_mid) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state_d   = rxd_s_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          cnt_d = cnt_q + c_cnt_one;
          if (cnt_q == c_cnt_last) begin
            cnt_d   = '0;
            shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == c_idx_last) begin
              state_d = ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + c_idx_one;
            end
          end
        end
        ST_STOP: begin
          cnt_d = cnt_q + c_cnt_one;
          if (cnt_q == c_cnt_last) begin
            cnt_d = '0;
            if (rxd_s_q) begin
              data_d  = shift_q;
              ready_d = 1'b1;
              ferr_d  = 1'b0;
              if (ready_q && !rd) begin
                overrun_d = 1'b1;
              end
              state_d = ST_IDLE;
            end else begin
              // Hold off in WAITHI so a break does not look like new frames.
              ferr_d  = 1'b1;
              state_d = ST_WAITHI;
            end
          end
        end
        ST_WAITHI: begin
          if (rxd_s_q) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_ready     = ready_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Directed scenarios plus random
//             frames with +/-3% bit-time error, compared against a byte-level
//             model of the receiver's output flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int BIT_NS = 1280;  // 16 ticks of 8 clk at 10 ns
  // rx_baud_clk rises at R; first tick edge R+13 misses the synchronizer,
  // start seen at R+93, mid start +8 ticks, stop sampled 9 bits later.
  localparam int STOP_EDGE_NS = 13 + 80 + 8 * 80 + 9 * 16 * 80;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       rx_baud_clk = 1'b0;
  logic       rxd         = 1'b1;
  logic       rd          = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of what the bus side should see.
  logic [7:0] m_data    = 8'h00;
  logic       m_ready   = 1'b0;
  logic       m_overrun = 1'b0;
  logic       m_ferr    = 1'b0;

  logic [7:0] rb;
  logic       rok;
  int         rbn;

  uart_rx #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_baud_clk (rx_baud_clk),
    .rxd         (rxd),
    .rd          (rd),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2;
    forever #40 rx_baud_clk = ~rx_baud_clk;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"},    32'(rx_data),      32'(m_data));
    check({tag, "_ready"},   32'(rx_ready),     32'(m_ready));
    check({tag, "_overrun"}, 32'(rx_overrun),   32'(m_overrun));
    check({tag, "_ferr"},    32'(rx_frame_err), 32'(m_ferr));
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic rd_same);
    if (stop_ok) begin
      if (rd_same)      m_overrun = 1'b0;
      else if (m_ready) m_overrun = 1'b1;
      m_ready = 1'b1;
      m_data  = b;
      m_ferr  = 1'b0;
    end else begin
      m_ferr = 1'b1;
      if (rd_same) begin
        m_ready   = 1'b0;
        m_overrun = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_data    = 8'h00;
    m_ready   = 1'b0;
    m_overrun = 1'b0;
    m_ferr    = 1'b0;
  endtask

  // Frame starts on a baud-clock rising edge; line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int bit_ns);
    @(posedge rx_baud_clk);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_ok;
    #(bit_ns);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    m_ready   = 1'b0;
    m_overrun = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Normal byte, then a read
    send_frame(8'hA5, 1'b1, BIT_NS);
    model_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    check_all("a5");
    pulse_rd();
    check_all("a5_rd");

    // Back-to-back bytes without a read
    send_frame(8'h3C, 1'b1, BIT_NS);
    model_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, BIT_NS);
    model_frame(8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    check_all("b2b");
    pulse_rd();
    check_all("b2b_rd");

    // Three-tick glitch, then a valid zero byte
    @(posedge rx_baud_clk);
    rxd = 1'b0;
    #240;
    rxd = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    check_all("glitch");
    send_frame(8'h00, 1'b1, BIT_NS);
    model_frame(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check_all("zero");
    pulse_rd();

    // Framing error followed by a 20-bit break, then release and 0xFF
    send_frame(8'h55, 1'b0, BIT_NS);
    model_frame(8'h55, 1'b0, 1'b0);
    #(20 * BIT_NS);
    @(negedge clk);
    check_all("break");
    rxd = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    check_all("break_rel");
    send_frame(8'hFF, 1'b1, BIT_NS);
    model_frame(8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    check_all("ff");

    // Read in the exact cycle the 0x81 stop bit is accepted
    fork
      send_frame(8'h81, 1'b1, BIT_NS);
      begin
        @(posedge rx_baud_clk);
        #(STOP_EDGE_NS - 8);
        rd = 1'b1;
        #10;
        rd = 1'b0;
      end
    join
    model_frame(8'h81, 1'b1, 1'b1);
    @(negedge clk);
    check_all("rd_coinc");

    // Reset during data bit 4 of 0x0F; the transmitter abandons it as well
    @(posedge rx_baud_clk);
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b1;  // bits 0..3 of 0x0F
      #(BIT_NS);
    end
    rxd = 1'b0;    // bit 4
    #(BIT_NS / 2);
    reset = 1'b1;
    rxd   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all("reset_mid");
    #(12 * BIT_NS);
    @(negedge clk);
    check_all("post_reset");
    send_frame(8'h7E, 1'b1, BIT_NS);
    model_frame(8'h7E, 1'b1, 1'b0);
    @(negedge clk);
    check_all("7e");
    pulse_rd();

    // Random frames, random reads, random bit time within +/-3%
    for (int k = 0; k < 24; k++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 7) != 0);
      rbn = BIT_NS - 38 + int'($urandom_range(0, 76));
      if ($urandom_range(0, 1) == 1) pulse_rd();
      repeat ($urandom_range(0, 3)) @(posedge rx_baud_clk);
      send_frame(rb, rok, rbn);
      model_frame(rb, rok, 1'b0);
      if (!rok) begin
        #(2 * BIT_NS);
        rxd = 1'b1;
        #(BIT_NS / 4);
      end
      @(negedge clk);
      check_all($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
